// File: rtl/cp0_exception_unit.sv
// MIPS coprocessor-0: Status/Cause/EPC registers, trap prioritisation, eret and
// mtc0/mfc0 access, plus a redirect-and-flush FSM that squashes wrong-path work.
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_E,
  input  logic        undef_E,
  input  logic        syscall_E,
  input  logic        break_point_E,
  input  logic        overflow_E,
  input  logic        eret_E,
  input  logic        mtc0_E,
  input  logic [4:0]  cp0_addr_E,
  input  logic [31:0] cp0_wdata_E,
  input  logic [31:0] pc_E,
  input  logic [5:0]  hw_int,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic        exc_redirect,
  output logic [31:0] exc_target,
  output logic        exc_flush,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [2:0]  CNT_INIT    = 3'(FLUSH_CYCLES - 1);
  localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        redirect_q, flush_q;
  logic [31:0] target_q;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req, act, trap, eret_go, wr;
  logic [4:0]  exc_code;

  always_comb begin
    int_req  = status_q[0] & ~status_q[1] & (|(cause_q[15:10] & status_q[15:10]));
    // Execute inputs belong to wrong-path instructions while flushing.
    act      = (state_q == IDLE) & valid_E;
    trap     = act & (int_req | undef_E | syscall_E | break_point_E | overflow_E);
    eret_go  = act & eret_E & ~trap;
    wr       = act & mtc0_E & ~trap & ~eret_E;

    exc_code = 5'd0;
    if (int_req)            exc_code = 5'd0;
    else if (undef_E)       exc_code = 5'd10;
    else if (syscall_E)     exc_code = 5'd8;
    else if (break_point_E) exc_code = 5'd9;
    else if (overflow_E)    exc_code = 5'd12;

    status_d        = status_q;
    cause_d         = cause_q;
    epc_d           = epc_q;
    cause_d[15:10]  = hw_int;

    if (trap) begin
      cause_d[6:2] = exc_code;
      // A nested trap keeps the EPC of the outermost exception.
      if (!status_q[1]) epc_d = pc_E;
      status_d[1] = 1'b1;
    end else if (eret_go) begin
      status_d[1] = 1'b0;
    end else if (wr) begin
      case (cp0_addr_E)
        5'd12:   status_d = cp0_wdata_E & STATUS_MASK;
        5'd13:   cause_d[9:8] = cp0_wdata_E[9:8];
        5'd14:   epc_d = cp0_wdata_E;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (cp0_raddr)
      5'd12:   cp0_rdata = status_q;
      5'd13:   cp0_rdata = cause_q;
      5'd14:   cp0_rdata = epc_q;
      default: cp0_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= 32'h0;
      cause_q  <= 32'h0;
      epc_q    <= 32'h0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      target_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          redirect_q <= 1'b0;
          if (trap || eret_go) begin
            state_q    <= FLUSH;
            cnt_q      <= CNT_INIT;
            redirect_q <= 1'b1;
            flush_q    <= 1'b1;
            target_q   <= trap ? EXC_VECTOR : epc_q;
          end
        end
        FLUSH: begin
          redirect_q <= 1'b0;
          if (cnt_q == 3'd0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign exc_redirect = redirect_q;
  assign exc_target   = target_q;
  assign exc_flush    = flush_q;
  assign status       = status_q;
  assign cause        = cause_q;
  assign epc          = epc_q;

endmodule

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
Coprocessor-0 exception handler for the pipelined MIPS core. It consumes the per-instruction exception flags raised by the decoder (undefined opcode, syscall, break), the ALU overflow flag and external hardware interrupts. It holds the Status (reg 12), Cause (reg 13) and EPC (reg 14) registers. On a trap or eret it redirects fetch and flushes the pipeline through a small state machine. It also serves mfc0/mtc0 accesses.

Parameters:
EXC_VECTOR, 32'h8000_0180, fetch target on any exception or interrupt
FLUSH_CYCLES, 3, cycles exc_flush stays high after a redirect (range 1..7)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid_E  input  1  Execute-stage slot holds a real instruction (not a bubble)
undef_E  input  1  undefined-opcode flag, pipelined from decode
syscall_E  input  1  syscall flag
break_point_E  input  1  break flag
overflow_E  input  1  signed arithmetic overflow from the ALU
eret_E  input  1  eret in Execute
mtc0_E  input  1  mtc0 in Execute
cp0_addr_E  input  5  CP0 register number for mtc0
cp0_wdata_E  input  32  mtc0 write data
pc_E  input  32  PC of the Execute instruction
hw_int  input  6  external interrupt lines, level sensitive
cp0_raddr  input  5  mfc0 read address
cp0_rdata  output  32  combinational read of Status, Cause or EPC; 0 for other addresses
exc_redirect  output  1  one-cycle fetch redirect pulse
exc_target  output  32  redirect address, valid while exc_redirect=1
exc_flush  output  1  flush the IF/ID/EX pipeline registers
status  output  32  Status register
cause  output  32  Cause register
epc  output  32  EPC register

Behaviour:
- Reset (sync): status, cause and epc = 0; exc_redirect = 0; exc_flush = 0; exc_target = 0; FSM = IDLE.
- Status fields: [0] IE, [1] EXL, [15:8] IM. All other bits read 0. mtc0 writes only IE, EXL and IM.
- Cause fields:
  - [6:2] ExcCode.
  - [15:10] IP[7:2] = hw_int, registered every cycle.
  - [9:8] IP[1:0] are software bits, written by mtc0.
  - All other bits read 0.
- EPC: mtc0 writes all 32 bits.
- Pending interrupt: int_req = IE & ~EXL & |(IP[7:2] & IM[7:2]). IP here is the registered value.
- Trap in IDLE: when valid_E=1 and any flag is set, select one cause by priority and its ExcCode:
  - int_req: 0
  - undef: 10
  - syscall: 8
  - break: 9
  - overflow: 12
- Trap at the posedge:
  - ExcCode is updated.
  - If EXL=0: EPC = pc_E and EXL set. If EXL=1: EPC is held and EXL stays 1 (nested trap).
  - The FSM goes to FLUSH.
  - Next cycle: exc_redirect=1 and exc_target=EXC_VECTOR.
- eret in IDLE (valid_E, no trap): EXL cleared, FSM goes to FLUSH, next cycle exc_redirect=1 and exc_target=EPC.
- A trap outranks eret and mtc0 on the same instruction; the write or eret is dropped.
- mtc0 with no trap: the register is written at the posedge. The new value is visible on cp0_rdata the next cycle; there is no bypass.
- FSM states and transitions:
  - IDLE -> FLUSH on trap or eret.
  - FLUSH holds exc_flush=1 for exactly FLUSH_CYCLES cycles, counted by an internal counter.
  - exc_redirect is high only in the first FLUSH cycle.
  - Last FLUSH cycle -> IDLE.
  - In FLUSH, all Execute inputs are ignored (wrong-path instructions). hw_int is still sampled into IP.
- Latency: event in cycle N -> exc_redirect and exc_flush high in N+1 -> exc_flush low from N+1+FLUSH_CYCLES.
- valid_E=0: no trap, no eret, no write, even if flags are set.
- A rst assertion during FLUSH aborts the flush immediately and restores all reset values.

Test Plan:
1. Reset, then valid_E=1, undef_E=1, pc_E=32'h0040_0010 → next cycle exc_redirect=1 and exc_target=32'h8000_0180; epc=32'h0040_0010, cause[6:2]=10, status[1]=1; exc_flush high 3 cycles, then low.
2. syscall_E=1 and overflow_E=1 together, EXL=0 → cause[6:2]=8 (syscall wins). Then eret_E=1 → exc_target=32'h0040_0010 (EPC) and status[1]=0.
3. Set status=32'h0000_0401 via mtc0 (IE=1, IM[2]=1), drive hw_int=6'b000001 → the registered IP becomes visible one cycle later → next valid instruction traps with ExcCode=0. Repeat with IE=0 → no trap.
4. Nested trap with EXL=1: break_point_E=1, pc_E=32'h0000_0100 → epc unchanged, cause[6:2]=9, redirect to EXC_VECTOR.
5. During FLUSH, drive undef_E=1 with valid_E=1 → ignored; no second redirect. A trap with valid_E=0 → ignored.
6. mtc0 to EPC (addr 14, wdata 32'hDEAD_BEE0) together with undef_E=1 → write dropped, EPC=pc_E. A plain mtc0 to addr 14 → cp0_rdata=32'hDEAD_BEE0 on the cycle after the write. Assert rst mid-FLUSH → exc_flush=0 and all registers 0 the next cycle.
